pipe_skid_stage: RTL



---
 rtl/pipe_pkg.sv | 14 +
 rtl/pipe_entry.sv | 37 +++
 rtl/pipe_skid_stage.sv | 102 ++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the skid-buffered pipeline stage.
package pipe_pkg;

  // The state encoding is the number of held entries, so it doubles as occupancy.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } pipe_state_e;

  localparam int CTRL_MAX_W = 64;
  localparam logic [CTRL_MAX_W-1:0] CTRL_BUBBLE = '0;

endpackage

// File: rtl/pipe_entry.sv
// One stage entry: payload plus control.
// Clearing control turns the entry into a bubble and leaves the payload unchanged.
module pipe_entry
  import pipe_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 8,
  parameter logic [DATA_W-1:0] PRESET_VAL = '0
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              load_i,
  input  logic              clr_ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic [DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0] ctrl_o
);

  logic [DATA_W-1:0] data_q;
  logic [CTRL_W-1:0] ctrl_q;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      data_q <= PRESET_VAL;
      ctrl_q <= CTRL_BUBBLE[CTRL_W-1:0];
    end else begin
      if (load_i) data_q <= data_i;
      if (clr_ctrl_i)  ctrl_q <= CTRL_BUBBLE[CTRL_W-1:0];
      else if (load_i) ctrl_q <= ctrl_i;
    end
  end

  assign data_o = data_q;
  assign ctrl_o = ctrl_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Pipeline stage register with a one-entry skid buffer and flush.
// Backpressure replaces a shared stall enable, and in_ready is a registered decode gated only by flush.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 8,
  parameter logic [DATA_W-1:0] PRESET_VAL = '0
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  // Handshake: an entry moves on a rising edge where valid && ready are both high.
  // A producer holding valid keeps its payload stable until that edge.
  pipe_state_e state_q, state_d;
  logic in_xfer, out_xfer;
  logic main_load, main_sel_skid, skid_load;
  logic [DATA_W-1:0] main_data, skid_data, main_din_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_din_ctrl;

  assign in_ready  = (state_q != FULL) && !flush;
  assign out_valid = (state_q != EMPTY);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;
  assign occupancy = state_q;

  always_comb begin
    state_d       = state_q;
    main_load     = 1'b0;
    main_sel_skid = 1'b0;
    skid_load     = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            state_d   = ONE;
            main_load = 1'b1;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            main_load = 1'b1;
          end else if (in_xfer) begin
            state_d   = FULL;
            skid_load = 1'b1;
          end else if (out_xfer) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_xfer) begin
            state_d       = ONE;
            main_load     = 1'b1;
            main_sel_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (srst) state_q <= EMPTY;
    else      state_q <= state_d;
  end

  assign main_din_data = main_sel_skid ? skid_data : in_data;
  assign main_din_ctrl = main_sel_skid ? skid_ctrl : in_ctrl;

  pipe_entry #(
    .DATA_W(DATA_W), .CTRL_W(CTRL_W), .PRESET_VAL(PRESET_VAL)
  ) u_main (
    .clk_i(clk), .srst_i(srst), .load_i(main_load), .clr_ctrl_i(flush),
    .data_i(main_din_data), .ctrl_i(main_din_ctrl),
    .data_o(main_data), .ctrl_o(main_ctrl)
  );

  pipe_entry #(
    .DATA_W(DATA_W), .CTRL_W(CTRL_W), .PRESET_VAL(PRESET_VAL)
  ) u_skid (
    .clk_i(clk), .srst_i(srst), .load_i(skid_load), .clr_ctrl_i(flush),
    .data_i(in_data), .ctrl_i(in_ctrl),
    .data_o(skid_data), .ctrl_o(skid_ctrl)
  );

  assign out_data = main_data;
  assign out_ctrl = out_valid ? main_ctrl : CTRL_BUBBLE[CTRL_W-1:0];

endmodule
